// File: rtl/decode_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of (pc, instr)
// pairs with combinational pre-decode of the head entry.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter bit RV64  = 1'b1,
  parameter bit HAS_M = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [3:0]               out_class,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [63:0]              out_imm,
  output logic                     out_wb,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] CLS_OP     = 4'd0;
  localparam logic [3:0] CLS_OPIMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;
  localparam logic [3:0] CLS_MUL    = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   stall_q, stall_d;
  logic [63:0]   pc_mem_q    [DEPTH];
  logic [63:0]   pc_mem_d    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_d     = stall_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = in_pc;
      instr_mem_d[wr_ptr_q] = in_instr;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    // Held-head cycles are counted regardless of flush; saturates at all-ones.
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  logic [31:0] head;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  op_class;
  logic [3:0]  cls;
  logic [63:0] imm;

  assign head   = instr_mem_q[rd_ptr_q];
  assign opcode = head[6:0];
  assign funct3 = head[14:12];
  assign funct7 = head[31:25];

  // Register-register ops: base, alternate (sub/sra only) or M-extension.
  always_comb begin
    op_class = CLS_ILL;
    if (funct7 == 7'b0000000)
      op_class = CLS_OP;
    else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
      op_class = CLS_OP;
    else if (funct7 == 7'b0000001 && HAS_M)
      op_class = CLS_MUL;
  end

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OPC_OP:      cls = op_class;
      OPC_OP32:    if (RV64) cls = op_class;
      OPC_OPIMM:   cls = CLS_OPIMM;
      OPC_OPIMM32: if (RV64) cls = CLS_OPIMM;
      OPC_LOAD:    cls = CLS_LOAD;
      OPC_STORE:   cls = CLS_STORE;
      OPC_BRANCH:  cls = CLS_BRANCH;
      OPC_JAL:     cls = CLS_JAL;
      OPC_JALR:    cls = CLS_JALR;
      OPC_LUI:     cls = CLS_LUI;
      OPC_AUIPC:   cls = CLS_AUIPC;
      OPC_SYSTEM:  cls = CLS_SYSTEM;
      default:     cls = CLS_ILL;
    endcase
    if (head[1:0] != 2'b11) cls = CLS_ILL;
  end

  always_comb begin
    imm = '0;
    case (cls)
      CLS_OPIMM, CLS_LOAD, CLS_JALR:
        imm = {{52{head[31]}}, head[31:20]};
      CLS_SYSTEM:
        imm = funct3[2] ? {59'b0, head[19:15]} : {{52{head[31]}}, head[31:20]};
      CLS_STORE:
        imm = {{52{head[31]}}, head[31:25], head[11:7]};
      CLS_BRANCH:
        imm = {{51{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm = {{32{head[31]}}, head[31:12], 12'b0};
      CLS_JAL:
        imm = {{43{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  assign out_pc       = pc_mem_q[rd_ptr_q];
  assign out_instr    = head;
  assign out_class    = cls;
  assign out_rs1      = head[19:15];
  assign out_rs2      = head[24:20];
  assign out_rd       = head[11:7];
  assign out_imm      = imm;
  assign out_wb       = !(cls == CLS_STORE || cls == CLS_BRANCH || cls == CLS_ILL);
  assign out_illegal  = (cls == CLS_ILL) && out_valid;
  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: two instances (RV64+M and RV32 without M)
// share the same stimulus; a negedge monitor checks every popped head entry.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid, a_out_wb, a_out_illegal;
  logic [63:0] a_out_pc, a_out_imm;
  logic [31:0] a_out_instr, a_stall;
  logic [3:0]  a_out_class;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
  logic [2:0]  a_count;

  logic        b_in_ready, b_out_valid, b_out_wb, b_out_illegal;
  logic [63:0] b_out_pc, b_out_imm;
  logic [31:0] b_out_instr, b_stall;
  logic [3:0]  b_out_class;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .RV64(1'b1), .HAS_M(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_instr(a_out_instr), .out_class(a_out_class), .out_rs1(a_out_rs1),
    .out_rs2(a_out_rs2), .out_rd(a_out_rd), .out_imm(a_out_imm),
    .out_wb(a_out_wb), .out_illegal(a_out_illegal), .count(a_count),
    .stall_cycles(a_stall)
  );

  decode_queue #(.DEPTH(DEPTH), .RV64(1'b0), .HAS_M(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_instr(b_out_instr), .out_class(b_out_class), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_imm(b_out_imm),
    .out_wb(b_out_wb), .out_illegal(b_out_illegal), .count(b_count),
    .stall_cycles(b_stall)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cls_a;
    logic [3:0]  cls_b;
    logic [63:0] imm_a;
    logic [63:0] imm_b;
    logic        wb_a;
    logic        wb_b;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    int          vi;
  } exp_t;

  vec_t        vecs [15];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_count = 0;
  int          exp_stall = 0;
  logic [63:0] next_pc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and advances the bench's occupancy/stall model.
  task automatic applyStimulus(input logic iv, input int vi, input logic ordy, input logic fl);
    logic push_ok, pop_ok;
    in_valid  = iv;
    in_pc     = next_pc;
    in_instr  = vecs[vi].instr;
    out_ready = ordy;
    flush     = fl;
    push_ok   = iv && (exp_count < DEPTH) && !fl;
    pop_ok    = ordy && (exp_count > 0) && !fl;
    if (exp_count > 0 && !ordy) exp_stall++;
    if (push_ok) sb.push_back('{next_pc, vi});
    if (iv) next_pc = next_pc + 64'd4;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_count = 0;
      sb.delete();
    end else begin
      exp_count = exp_count + int'(push_ok) - int'(pop_ok);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && a_out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_pop: got pc %h, want no entry", a_out_pc);
      end else begin
        exp_t        e;
        vec_t        v;
        logic [31:0] ins;
        e   = sb.pop_front();
        v   = vecs[e.vi];
        ins = v.instr;
        checkOutput("a_pc",      a_out_pc, e.pc);
        checkOutput("a_instr",   64'(a_out_instr), 64'(ins));
        checkOutput("a_class",   64'(a_out_class), 64'(v.cls_a));
        checkOutput("a_rs1",     64'(a_out_rs1), 64'(ins[19:15]));
        checkOutput("a_rs2",     64'(a_out_rs2), 64'(ins[24:20]));
        checkOutput("a_rd",      64'(a_out_rd), 64'(ins[11:7]));
        checkOutput("a_imm",     a_out_imm, v.imm_a);
        checkOutput("a_wb",      64'(a_out_wb), 64'(v.wb_a));
        checkOutput("a_illegal", 64'(a_out_illegal), 64'(v.cls_a == 4'd15));
        checkOutput("b_valid",   64'(b_out_valid), 64'd1);
        checkOutput("b_pc",      b_out_pc, e.pc);
        checkOutput("b_instr",   64'(b_out_instr), 64'(ins));
        checkOutput("b_class",   64'(b_out_class), 64'(v.cls_b));
        checkOutput("b_rd",      64'(b_out_rd), 64'(ins[11:7]));
        checkOutput("b_rs1",     64'(b_out_rs1), 64'(ins[19:15]));
        checkOutput("b_rs2",     64'(b_out_rs2), 64'(ins[24:20]));
        checkOutput("b_imm",     b_out_imm, v.imm_b);
        checkOutput("b_wb",      64'(b_out_wb), 64'(v.wb_b));
        checkOutput("b_illegal", 64'(b_out_illegal), 64'(v.cls_b == 4'd15));
      end
    end
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 4'd1,  4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[1]  = '{32'hFE512E23, 4'd3,  4'd3,  64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
    vecs[2]  = '{32'h800001B7, 4'd7,  4'd7,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1};
    vecs[3]  = '{32'hFE208CE3, 4'd4,  4'd4,  64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0};
    vecs[4]  = '{32'h001000EF, 4'd5,  4'd5,  64'h0000_0000_0000_0800, 64'h0000_0000_0000_0800, 1'b1, 1'b1};
    vecs[5]  = '{32'h3008D2F3, 4'd9,  4'd9,  64'h0000_0000_0000_0011, 64'h0000_0000_0000_0011, 1'b1, 1'b1};
    vecs[6]  = '{32'h0101A203, 4'd2,  4'd2,  64'h0000_0000_0000_0010, 64'h0000_0000_0000_0010, 1'b1, 1'b1};
    vecs[7]  = '{32'h0020803B, 4'd0,  4'd15, 64'h0,                   64'h0,                   1'b1, 1'b0};
    vecs[8]  = '{32'h022080B3, 4'd10, 4'd15, 64'h0,                   64'h0,                   1'b1, 1'b0};
    vecs[9]  = '{32'h00000000, 4'd15, 4'd15, 64'h0,                   64'h0,                   1'b0, 1'b0};
    vecs[10] = '{32'h40001033, 4'd15, 4'd15, 64'h0,                   64'h0,                   1'b0, 1'b0};
    vecs[11] = '{32'h00008067, 4'd6,  4'd6,  64'h0,                   64'h0,                   1'b1, 1'b1};
    vecs[12] = '{32'h00001117, 4'd8,  4'd8,  64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 1'b1, 1'b1};
    vecs[13] = '{32'h4030D093, 4'd1,  4'd1,  64'h0000_0000_0000_0403, 64'h0000_0000_0000_0403, 1'b1, 1'b1};
    vecs[14] = '{32'hFFE0809B, 4'd1,  4'd15, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,                   1'b1, 1'b0};

    next_pc   = 64'h0000_0000_8000_0000;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    checkOutput("rst_in_ready",  64'(a_in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("rst_count",     64'(a_count), 64'd0);
    checkOutput("rst_stall",     64'(a_stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // First entry visible the cycle after its push.
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    checkOutput("t1_valid", 64'(a_out_valid), 64'd1);
    checkOutput("t1_count", 64'(a_count), 64'd1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t1_empty", 64'(a_out_valid), 64'd0);

    // Overfill by one, then pop while full, then drain across the wrap.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i == DEPTH + 1) checkOutput("t2_ready_low", 64'(a_in_ready), 64'd0);
      applyStimulus(1'b1, i, 1'b0, 1'b0);
    end
    checkOutput("t2_count_full", 64'(a_count), 64'(DEPTH));
    checkOutput("t2_stall",      64'(a_stall), 64'(exp_stall));
    checkOutput("t2_stall_abs",  64'(a_stall), 64'd4);
    applyStimulus(1'b1, 6, 1'b1, 1'b0);
    checkOutput("t3_count", 64'(a_count), 64'(DEPTH - 1));
    checkOutput("t3_ready", 64'(a_in_ready), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t3_drained", 64'(a_count), 64'd0);

    // Flush with three entries held while a fourth is offered.
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    checkOutput("t4_count3", 64'(a_count), 64'd3);
    applyStimulus(1'b1, 4, 1'b1, 1'b1);
    checkOutput("t4_count0", 64'(a_count), 64'd0);
    checkOutput("t4_valid0", 64'(a_out_valid), 64'd0);
    applyStimulus(1'b1, 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t4_stall", 64'(a_stall), 64'(exp_stall));
    checkOutput("t4_stall_abs", 64'(a_stall), 64'd6);

    // Back-to-back push and pop through the remaining vectors.
    applyStimulus(1'b1, 6, 1'b1, 1'b0);
    for (int vi = 7; vi < 15; vi++) begin
      applyStimulus(1'b1, vi, 1'b1, 1'b0);
      checkOutput("t5_count_steady", 64'(a_count), 64'd1);
    end
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t5_empty", 64'(a_count), 64'd0);

    // Asynchronous reset with two entries held.
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0);
    checkOutput("t6_count2", 64'(a_count), 64'd2);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_valid0", 64'(a_out_valid), 64'd0);
    checkOutput("t6_count0", 64'(a_count), 64'd0);
    checkOutput("t6_ready1", 64'(a_in_ready), 64'd1);
    checkOutput("t6_stall0", 64'(a_stall), 64'd0);
    sb.delete();
    exp_count = 0;
    exp_stall = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("t6_after_empty", 64'(a_count), 64'd0);
    checkOutput("sb_leftover", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
